// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and the
// default memory depth.
package lsu_pkg;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeIllegal = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_e;

    localparam int unsigned MEM_WORDS_DEFAULT = 41;

    // Alignment/encoding fault only; the range check depends on module parameters.
    function automatic logic lsu_bad_access(input size_e size, input logic [1:0] lo);
        unique case (size)
            SizeByte:    return 1'b0;
            SizeHalf:    return lo[0];
            SizeWord:    return |lo;
            SizeIllegal: return 1'b1;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts/extends load data and merges sub-word store
// data into the word read back from memory.
module lsu_lane
    import lsu_pkg::*;
(
    input  size_e       i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        unique case (i_lane)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_load = i_rdata;
        case (i_size)
            SizeByte: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SizeHalf: o_load = {{16{i_signed & w_half[15]}}, w_half};
            default:  o_load = i_rdata;
        endcase
    end

    always_comb begin
        o_merge = i_rdata;
        case (i_size)
            SizeByte: begin
                unique case (i_lane)
                    2'd0: o_merge[7:0]   = i_wdata[7:0];
                    2'd1: o_merge[15:8]  = i_wdata[7:0];
                    2'd2: o_merge[23:16] = i_wdata[7:0];
                    2'd3: o_merge[31:24] = i_wdata[7:0];
                    default: o_merge = i_rdata;
                endcase
            end
            SizeHalf: begin
                if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
                else           o_merge[15:0]  = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: word stores write directly, sub-word stores
// read-modify-write, loads read then extract; errors respond without memory access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_write_signal,
    input  logic [31:0]       mem_read_data
);

    state_e            r_state;
    logic              r_write;
    size_e             r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_write_data;
    logic              r_mem_write_signal;

    size_e             w_req_size;
    logic [ADDR_W-1:0] w_req_index;
    logic [ADDR_W-1:0] w_cur_index;
    logic              w_err;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    assign w_req_size  = size_e'(req_size);
    assign w_req_index = {2'b00, req_addr[ADDR_W-1:2]};
    assign w_cur_index = {2'b00, r_addr[ADDR_W-1:2]};
    assign w_err       = lsu_bad_access(w_req_size, req_addr[1:0]) ||
                         (w_req_index >= ADDR_W'(MEM_WORDS));

    assign req_ready        = (r_state == IDLE) && !reset;
    assign resp_valid       = r_resp_valid;
    assign resp_rdata       = r_resp_rdata;
    assign resp_err         = r_resp_err;
    assign mem_address      = r_mem_address;
    assign mem_write_data   = r_mem_write_data;
    assign mem_write_signal = r_mem_write_signal;

    lsu_lane u_lane (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_lane   (r_addr[1:0]),
        .i_rdata  (mem_read_data),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // Outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_write            <= 1'b0;
            r_size             <= SizeByte;
            r_signed           <= 1'b0;
            r_addr             <= '0;
            r_wdata            <= '0;
            r_resp_valid       <= 1'b0;
            r_resp_rdata       <= '0;
            r_resp_err         <= 1'b0;
            r_mem_address      <= '0;
            r_mem_write_data   <= '0;
            r_mem_write_signal <= 1'b0;
        end else begin
            r_resp_valid       <= 1'b0;
            r_resp_err         <= 1'b0;
            r_mem_write_signal <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= w_req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (req_write && (w_req_size == SizeWord)) begin
                            r_state            <= WR;
                            r_mem_address      <= w_req_index;
                            r_mem_write_data   <= req_wdata;
                            r_mem_write_signal <= 1'b1;
                        end else begin
                            r_state       <= RD;
                            r_mem_address <= w_req_index;
                        end
                    end
                end
                RD: r_state <= CAP;
                CAP: begin
                    if (r_write) begin
                        r_state            <= WR;
                        r_mem_address      <= w_cur_index;
                        r_mem_write_data   <= w_merge;
                        r_mem_write_signal <= 1'b1;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                    end
                end
                WR: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// compared against a byte-addressed memory model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 41;
    localparam int unsigned ADDR_W    = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_signed = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_write_signal;
    logic [31:0]       mem_read_data = '0;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [31:0] mem [MEM_WORDS];
    logic [7:0]  ref_bytes [MEM_WORDS*4];
    logic [31:0] ref_rdata = '0;
    logic [31:0] last_rdata;
    int          wr_count = 0;
    int          resp_count = 0;
    logic [31:0] wr_addr = '0;

    load_store_unit #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_signal (mem_write_signal),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous data memory: write when enabled, otherwise register the read.
    always @(posedge clk) begin
        if (mem_write_signal) begin
            if (mem_address < MEM_WORDS) mem[mem_address] <= mem_write_data;
        end else begin
            mem_read_data <= (mem_address < MEM_WORDS) ? mem[mem_address] : 32'h0;
        end
    end

    always @(negedge clk) begin
        if (mem_write_signal) begin
            wr_count = wr_count + 1;
            wr_addr  = mem_address;
        end
        if (resp_valid) resp_count = resp_count + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
    endfunction

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd);
        logic        e_err;
        int          e_lat;
        int          e_wr;
        int          nb;
        int          lat;
        bit          got;
        logic [31:0] idx;
        longint      v;

        idx   = addr >> 2;
        e_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                (sz == 2'b10 && addr[1:0] != 2'b00) || (idx >= MEM_WORDS);
        nb    = 1 << sz;
        if (e_err) begin
            e_lat = 1; e_wr = 0; ref_rdata = 32'h0;
        end else if (wr) begin
            for (int k = 0; k < nb; k++) ref_bytes[int'(addr) + k] = wd[8*k +: 8];
            e_lat = (sz == 2'b10) ? 2 : 4;
            e_wr  = 1;
        end else begin
            v = 0;
            for (int k = 0; k < nb; k++) v += longint'(ref_bytes[int'(addr) + k]) << (8 * k);
            if (sg && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
            ref_rdata = 32'(v);
            e_lat = 3; e_wr = 0;
        end

        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        check_eq("ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_count  = 0;
        lat = 0;
        got = 0;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                lat = i;
            end
        end
        if (!got) check_eq("resp_timeout", 32'd0, 32'd1);
        last_rdata = resp_rdata;
        check_eq("latency", lat, e_lat);
        check_eq("resp_err", {31'b0, resp_err}, {31'b0, e_err});
        check_eq("resp_rdata", resp_rdata, ref_rdata);
        check_eq("write_count", wr_count, e_wr);
        if (e_wr == 1) begin
            check_eq("write_addr", wr_addr, idx);
            check_eq("mem_word", mem[idx], ref_word(int'(idx)));
        end
        @(negedge clk);
        check_eq("pulse_end", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        int prev;
        int n_acc;
        int rc;
        logic [31:0] a;

        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 32'h0;
        for (int i = 0; i < int'(MEM_WORDS) * 4; i++) ref_bytes[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, req_ready}, 32'd0);
        check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check_eq("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_mem_addr", mem_address, 32'h0);
        check_eq("rst_mem_wdata", mem_write_data, 32'h0);
        check_eq("rst_mem_we", {31'b0, mem_write_signal}, 32'd0);
        reset = 1'b0;

        // Directed scenarios.
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
        check_eq("dir_ws_addr", wr_addr, 32'd5);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check_eq("dir_lw", last_rdata, 32'hDEADBEEF);
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h000000AA);
        check_eq("dir_sb_word", mem[5], 32'hDEADAAEF);
        do_req(1'b0, 2'b00, 1'b1, 32'h15, 32'h0);
        check_eq("dir_lb_signed", last_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0);
        check_eq("dir_lb_unsigned", last_rdata, 32'h000000AA);
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001);
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);
        check_eq("dir_lh_signed", last_rdata, 32'hFFFF8001);
        do_req(1'b1, 2'b01, 1'b0, 32'h15, 32'h1234);
        check_eq("dir_half_misalign_rdata", last_rdata, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'hA4, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'hA0, 32'hCAFEF00D);
        do_req(1'b0, 2'b10, 1'b0, 32'hA0, 32'h0);
        check_eq("dir_lw_last", last_rdata, 32'hCAFEF00D);
        do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);

        // Reset during CAP of a byte store abandons it.
        rc = resp_count;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_count  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready", {31'b0, req_ready}, 32'd0);
        check_eq("mid_rst_rdata", resp_rdata, 32'h0);
        check_eq("mid_rst_mem_addr", mem_address, 32'h0);
        check_eq("mid_rst_mem_wdata", mem_write_data, 32'h0);
        check_eq("mid_rst_mem_we", {31'b0, mem_write_signal}, 32'd0);
        check_eq("mid_rst_err", {31'b0, resp_err}, 32'd0);
        reset = 1'b0;
        ref_rdata = 32'h0;
        @(negedge clk);
        check_eq("post_rst_ready", {31'b0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        check_eq("abandon_no_write", wr_count, 32'd0);
        check_eq("abandon_no_resp", resp_count - rc, 32'd0);
        check_eq("abandon_mem", mem[5], ref_word(5));

        // req_valid held high: one accept per IDLE visit, load spacing 3+1.
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h14;
        req_valid = 1'b1;
        prev = -1;
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready) begin
                if (prev >= 0) check_eq("b2b_gap", i - prev, 32'd4);
                prev = i;
                n_acc++;
            end
        end
        req_valid = 1'b0;
        check_eq("b2b_accepts", n_acc, 32'd4);
        ref_rdata = ref_word(5);
        @(negedge clk);

        // Random traffic against the byte-level model.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, MEM_WORDS * 4 + 7);
            do_req(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
